uop_seq_expander: RTL and testbench

Expands an accepted fused-case index into its micro-op stream, one uop per beat, by reading the case tables (length, ops, immediates, use-imm flags, FF mask) from the shared length-table package. It is the consumer side of those tables: the recognizer front end hands it a case ID, and it drives the uop pipeline with a valid/ready stream. Outputs are registered; case N+1 follows case N with no bubble.

---
 rtl/len_table_pkg.sv | 45 ++++
 rtl/uop_pkg.sv | 33 +++
 rtl/uop_lut_rd.sv | 42 ++++
 rtl/uop_seq_expander.sv | 165 ++++++++++++++++
 tb/tb_uop_seq_expander.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/len_table_pkg.sv
// Shared fused-case tables: opcode set, per-case sequence length and the
// per-slot opcode, immediate, use-immediate and register-boundary (FF) data.
// Slots at or beyond a case's length are OP_NOP padding.
package len_table_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_SAR = 3'd4
   } op_t;

   localparam int N_CASE  = 4;
   localparam int MAX_LEN = 4;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   localparam logic [LEN_W-1:0] LEN_LUT [N_CASE] = '{
      LEN_W'(2), LEN_W'(2), LEN_W'(2), LEN_W'(3)
   };

   localparam op_t OP_LUT [N_CASE][MAX_LEN] = '{
      '{OP_AND, OP_AND, OP_NOP, OP_NOP},
      '{OP_ADD, OP_ADD, OP_NOP, OP_NOP},
      '{OP_SUB, OP_SAR, OP_NOP, OP_NOP},
      '{OP_ADD, OP_ADD, OP_ADD, OP_NOP}
   };

   localparam logic [31:0] IMM_LUT [N_CASE][MAX_LEN] = '{
      '{32'h0000_00FF, 32'h0000_0F00, 32'h0000_0000, 32'h0000_0000},
      '{32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000},
      '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000},
      '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0000}
   };

   // Bit i of each mask belongs to slot i of the case.
   localparam logic [MAX_LEN-1:0] USE_IMM_LUT [N_CASE] = '{
      4'b0011, 4'b0010, 4'b0010, 4'b0111
   };

   localparam logic [MAX_LEN-1:0] FF_MASK_LUT [N_CASE] = '{
      4'b0001, 4'b0010, 4'b0011, 4'b0000
   };

endpackage

// File: rtl/uop_pkg.sv
// Micro-op stream types: the registered output beat and the expander states.
package uop_pkg;

   import len_table_pkg::*;

   localparam int UOP_IDX_W = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);
   localparam int UOP_TAG_W = 4;

   typedef struct packed {
      op_t                  op;
      logic [31:0]          imm;
      logic                 use_imm;
      logic                 ff;
      logic [UOP_IDX_W-1:0] idx;
      logic                 first;
      logic                 last;
      logic [UOP_TAG_W-1:0] tag;
   } uop_beat_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_e;

   // Value the output register takes on reset: all-zero payload, NOP opcode.
   function automatic uop_beat_t uop_beat_reset();
      uop_beat_t b;
      b         = '0;
      b.op      = OP_NOP;
      return b;
   endfunction

endpackage

// File: rtl/uop_lut_rd.sv
// Combinational case-table lookup: (case, idx) -> slot payload plus the case
// length and whether the case ID names a defined case.
module uop_lut_rd #(
   parameter int N_CASE  = len_table_pkg::N_CASE,
   parameter int MAX_LEN = len_table_pkg::MAX_LEN,
   parameter int CASE_W  = 3,
   parameter int IDX_W   = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN)
) (
   input  logic [CASE_W-1:0]              rd_case,
   input  logic [IDX_W-1:0]               rd_idx,
   output len_table_pkg::op_t             rd_op,
   output logic [31:0]                    rd_imm,
   output logic                           rd_use_imm,
   output logic                           rd_ff,
   output logic [len_table_pkg::LEN_W-1:0] rd_len,
   output logic                           rd_in_range
);

   // Select the addressed slot by decoding case and index; unmatched IDs read as NOP/zero.
   always_comb begin
      rd_op       = len_table_pkg::OP_NOP;
      rd_imm      = 32'h0000_0000;
      rd_use_imm  = 1'b0;
      rd_ff       = 1'b0;
      rd_len      = {len_table_pkg::LEN_W{1'b0}};
      rd_in_range = ({1'b0, rd_case} < (CASE_W+1)'(N_CASE));
      for (int c = 0; c < N_CASE; c++) begin
         rd_len = (rd_case == CASE_W'(c)) ? len_table_pkg::LEN_LUT[c] : rd_len;
         for (int i = 0; i < MAX_LEN; i++) begin
            rd_op      = ((rd_case == CASE_W'(c)) && (rd_idx == IDX_W'(i)))
                         ? len_table_pkg::OP_LUT[c][i] : rd_op;
            rd_imm     = ((rd_case == CASE_W'(c)) && (rd_idx == IDX_W'(i)))
                         ? len_table_pkg::IMM_LUT[c][i] : rd_imm;
            rd_use_imm = ((rd_case == CASE_W'(c)) && (rd_idx == IDX_W'(i)))
                         ? len_table_pkg::USE_IMM_LUT[c][i] : rd_use_imm;
            rd_ff      = ((rd_case == CASE_W'(c)) && (rd_idx == IDX_W'(i)))
                         ? len_table_pkg::FF_MASK_LUT[c][i] : rd_ff;
         end
      end
   end

endmodule

// File: rtl/uop_seq_expander.sv
// Expands an accepted fused-case ID into its uop stream, one registered beat
// per handshake. The last beat of one case can hand straight over to beat 0 of
// the next request, so in_ready is combinational from out_ready.
module uop_seq_expander
   import uop_pkg::*;
#(
   parameter int N_CASE  = len_table_pkg::N_CASE,
   parameter int MAX_LEN = len_table_pkg::MAX_LEN,
   parameter int CASE_W  = 3,
   parameter int TAG_W   = 4,
   parameter int IDX_W   = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CASE_W-1:0]  in_case,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output len_table_pkg::op_t out_op,
   output logic [31:0]        out_imm,
   output logic               out_use_imm,
   output logic               out_ff,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_first,
   output logic               out_last,
   output logic [TAG_W-1:0]   out_tag,
   output logic               err_bad_case
);

   localparam int LEN_W = len_table_pkg::LEN_W;

   seq_state_e               state_r;
   seq_state_e               next_state_s;
   uop_beat_t                beat_r;
   logic [CASE_W-1:0]        case_r;
   logic                     err_r;

   logic                     accept_s;
   logic                     good_req_s;
   logic                     load_new_s;
   logic                     load_next_s;
   logic [CASE_W-1:0]        rd_case_s;
   logic [IDX_W-1:0]         rd_idx_s;
   logic                     rd_last_s;

   len_table_pkg::op_t       lut_op_s;
   logic [31:0]              lut_imm_s;
   logic                     lut_use_imm_s;
   logic                     lut_ff_s;
   logic [LEN_W-1:0]         lut_len_s;
   logic                     lut_in_range_s;

   // Idle, or the held beat is the last one and is leaving this cycle.
   assign in_ready = (state_r == IDLE) || (out_ready && beat_r.last);
   assign accept_s = in_valid && in_ready;

   // A new request reads its beat 0; otherwise read the slot after the held beat.
   assign rd_case_s = accept_s ? in_case : case_r;
   assign rd_idx_s  = accept_s ? IDX_W'(0) : (IDX_W'(beat_r.idx) + IDX_W'(1));

   uop_lut_rd #(
      .N_CASE  (N_CASE),
      .MAX_LEN (MAX_LEN),
      .CASE_W  (CASE_W),
      .IDX_W   (IDX_W)
   ) u_lut_rd (
      .rd_case     (rd_case_s),
      .rd_idx      (rd_idx_s),
      .rd_op       (lut_op_s),
      .rd_imm      (lut_imm_s),
      .rd_use_imm  (lut_use_imm_s),
      .rd_ff       (lut_ff_s),
      .rd_len      (lut_len_s),
      .rd_in_range (lut_in_range_s)
   );

   // A request only produces beats when it names a defined, non-empty case.
   assign good_req_s = accept_s && lut_in_range_s && (lut_len_s != LEN_W'(0));
   assign rd_last_s  = (LEN_W'(rd_idx_s) == (lut_len_s - LEN_W'(1)));

   // Next-state and load decisions; outputs hold whenever no handshake occurs.
   always_comb begin
      next_state_s = state_r;
      load_new_s   = 1'b0;
      load_next_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (good_req_s) begin
               next_state_s = ISSUE;
               load_new_s   = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            if (out_ready) begin
               if (!beat_r.last) begin
                  next_state_s = ISSUE;
                  load_next_s  = 1'b1;
               end else if (good_req_s) begin
                  next_state_s = ISSUE;
                  load_new_s   = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = ISSUE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Output beat register and the case that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_r <= uop_beat_reset();
         case_r <= CASE_W'(0);
      end else if (load_new_s || load_next_s) begin
         beat_r.op      <= lut_op_s;
         beat_r.imm     <= lut_imm_s;
         beat_r.use_imm <= lut_use_imm_s;
         beat_r.ff      <= lut_ff_s;
         beat_r.idx     <= UOP_IDX_W'(rd_idx_s);
         beat_r.first   <= (rd_idx_s == IDX_W'(0));
         beat_r.last    <= rd_last_s;
         beat_r.tag     <= load_new_s ? UOP_TAG_W'(in_tag) : beat_r.tag;
         case_r         <= rd_case_s;
      end
   end

   // One-cycle error pulse for an accepted request that names no usable case.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= accept_s && !good_req_s;
      end
   end

   assign out_valid    = (state_r == ISSUE);
   assign out_op       = beat_r.op;
   assign out_imm      = beat_r.imm;
   assign out_use_imm  = beat_r.use_imm;
   assign out_ff       = beat_r.ff;
   assign out_idx      = IDX_W'(beat_r.idx);
   assign out_first    = beat_r.first;
   assign out_last     = beat_r.last;
   assign out_tag      = TAG_W'(beat_r.tag);
   assign err_bad_case = err_r;

endmodule

// File: tb/tb_uop_seq_expander.sv
// Bench for uop_seq_expander: directed sequences then random valid/ready
// traffic, all checked every cycle against a queue-based reference model.
module tb_uop_seq_expander;

   import len_table_pkg::*;

   typedef struct packed {
      op_t         op;
      logic [31:0] imm;
      logic        use_imm;
      logic        ff;
      logic [1:0]  idx;
      logic        first;
      logic        last;
      logic [3:0]  tag;
   } exp_beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_case;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   op_t         out_op;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic        out_ff;
   logic [1:0]  out_idx;
   logic        out_first;
   logic        out_last;
   logic [3:0]  out_tag;
   logic        err_bad_case;

   always #5 clk = ~clk;

   uop_seq_expander dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_case      (in_case),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_op       (out_op),
      .out_imm      (out_imm),
      .out_use_imm  (out_use_imm),
      .out_ff       (out_ff),
      .out_idx      (out_idx),
      .out_first    (out_first),
      .out_last     (out_last),
      .out_tag      (out_tag),
      .err_bad_case (err_bad_case)
   );

   // Intended case contents.
   int          tb_len [4] = '{2, 2, 2, 3};
   op_t         tb_op  [4][4] = '{
      '{OP_AND, OP_AND, OP_NOP, OP_NOP},
      '{OP_ADD, OP_ADD, OP_NOP, OP_NOP},
      '{OP_SUB, OP_SAR, OP_NOP, OP_NOP},
      '{OP_ADD, OP_ADD, OP_ADD, OP_NOP}
   };
   logic [31:0] tb_imm [4][4] = '{
      '{32'h0000_00FF, 32'h0000_0F00, 32'h0, 32'h0},
      '{32'h0000_0001, 32'h0000_0002, 32'h0, 32'h0},
      '{32'h0000_0000, 32'h0000_0005, 32'h0, 32'h0},
      '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0}
   };
   logic [3:0]  tb_use [4] = '{4'b0011, 4'b0010, 4'b0010, 4'b0111};
   logic [3:0]  tb_ff  [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000};

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_beat_t   exp_q[$];
   logic        err_exp;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: an accepted request appends its beats, or flags an error pulse.
   task automatic push_case(input logic [2:0] c, input logic [3:0] t);
      int ci;
      exp_beat_t b;
      ci = int'(c);
      if (ci < 4 && tb_len[ci] >= 1) begin
         for (int i = 0; i < tb_len[ci]; i++) begin
            b.op      = tb_op[ci][i];
            b.imm     = tb_imm[ci][i];
            b.use_imm = tb_use[ci][i];
            b.ff      = tb_ff[ci][i];
            b.idx     = 2'(i);
            b.first   = (i == 0);
            b.last    = (i == tb_len[ci] - 1);
            b.tag     = t;
            exp_q.push_back(b);
         end
      end else begin
         err_exp = 1'b1;
      end
   endtask

   // One clock: check what the DUT shows, drive inputs, advance the model.
   task automatic step(input logic v, input logic [2:0] c, input logic [3:0] t,
                       input logic ordy, input logic r, output logic acc, output logic vis);
      logic exp_rdy;
      @(negedge clk);
      vis = out_valid;
      check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check_eq("beat", 64'({out_op, out_imm, out_use_imm, out_ff, out_idx,
                               out_first, out_last, out_tag}), 64'(exp_q[0]));
      end
      check_eq("err_bad_case", 64'(err_bad_case), 64'(err_exp));
      rst       = r;
      in_valid  = v;
      in_case   = c;
      in_tag    = t;
      out_ready = ordy;
      #1;
      exp_rdy = (exp_q.size() == 0) || (ordy && exp_q[0].last);
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      err_exp = 1'b0;
      acc     = 1'b0;
      if (r) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && ordy) begin
            void'(exp_q.pop_front());
         end
         if (v && exp_rdy) begin
            acc = 1'b1;
            push_case(c, t);
         end
      end
   endtask

   initial begin
      logic       acc;
      logic       vis;
      int         k;
      int         vcount;
      logic [2:0] b2b [3] = '{3'd0, 3'd1, 3'd3};

      rst = 1'b1; in_valid = 1'b0; in_case = 3'd0; in_tag = 4'd0; out_ready = 1'b0;
      err_exp = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_err", 64'(err_bad_case), 64'd0);
      check_eq("rst_op", 64'(out_op), 64'(OP_NOP));
      check_eq("rst_payload", 64'({out_imm, out_use_imm, out_ff, out_idx,
                                   out_first, out_last, out_tag}), 64'd0);

      // Case 3 with out_ready high: three ADD beats, idx 0..2.
      step(1'b1, 3'd3, 4'hA, 1'b1, 1'b0, acc, vis);
      repeat (4) step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);

      // Case 2 with beat 0 stalled for 3 cycles.
      step(1'b1, 3'd2, 4'h3, 1'b0, 1'b0, acc, vis);
      repeat (3) step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, acc, vis);
      repeat (3) step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);

      // Cases 0, 1, 3 back to back: 7 beats in 7 cycles.
      k = 0;
      vcount = 0;
      for (int s = 0; s < 9; s++) begin
         step(k < 3, (k < 3) ? b2b[k] : 3'd0, 4'(k + 5), 1'b1, 1'b0, acc, vis);
         if (acc) k++;
         if (vis) vcount++;
      end
      check_eq("b2b_accepts", 64'(k), 64'd3);
      check_eq("b2b_beats", 64'(vcount), 64'd7);

      // Out-of-range case: error pulse, no beats, then case 0 runs normally.
      step(1'b1, 3'd5, 4'h7, 1'b1, 1'b0, acc, vis);
      step(1'b1, 3'd0, 4'h8, 1'b1, 1'b0, acc, vis);
      repeat (3) step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);

      // Reset during beat 1 of case 3, with a request presented alongside reset.
      step(1'b1, 3'd3, 4'h6, 1'b1, 1'b0, acc, vis);
      step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);
      step(1'b1, 3'd2, 4'hE, 1'b1, 1'b1, acc, vis);
      step(1'b1, 3'd1, 4'h9, 1'b1, 1'b0, acc, vis);
      repeat (3) step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);

      // Random valid/ready traffic with occasional bad IDs and resets.
      for (int s = 0; s < 600; s++) begin
         step($urandom_range(0, 99) < 60,
              ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
              4'($urandom),
              $urandom_range(0, 99) < 70,
              $urandom_range(0, 199) == 0,
              acc, vis);
      end
      repeat (8) step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, acc, vis);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
